// File: rtl/lrf_pkg.sv
// Shared definitions for the LRF frame feeder and the LRF core.
//  - derivations of stream word width, words per frame and fusion offset
//  - FSM state encoding (IDLE, STREAM, FLUSH, DONE)
//  - frame_sel(): maps an interleaved frame pointer to a frame-store frame index
package lrf_pkg;

  typedef logic [1:0] lrf_state_t;

  localparam lrf_state_t StIdle   = 2'd0;
  localparam lrf_state_t StStream = 2'd1;
  localparam lrf_state_t StFlush  = 2'd2;
  localparam lrf_state_t StDone   = 2'd3;

  function automatic int unsigned calc_word_w(input int unsigned pixel_width,
                                              input int unsigned pixels_per_beat);
    return pixel_width * pixels_per_beat;
  endfunction

  function automatic int unsigned calc_words(input int unsigned image_dim,
                                             input int unsigned pixels_per_beat);
    return (image_dim * image_dim) / pixels_per_beat;
  endfunction

  function automatic int unsigned calc_offs(input int unsigned n_fuse_count);
    return 32'd1 << n_fuse_count;
  endfunction

  // Even pointers walk the new frames in order; odd pointers replay the frame OFFS behind,
  // clamped to frame 0 until enough history exists.
  function automatic int unsigned frame_sel(input int unsigned fp, input int unsigned offs);
    if ((fp % 2) == 0) begin
      return fp / 2;
    end else if (fp > 2 * offs) begin
      return fp / 2 - offs;
    end else begin
      return 0;
    end
  endfunction

endpackage

// File: rtl/lrf_axis_skid2.sv
// Two-entry {data,last} FIFO used as the AXI4-Stream output stage.
//  clk_i, rst_ni          clock, async active-low reset
//  push_i/push_data_i/    enqueue one word (caller guarantees space)
//  push_last_i
//  pop_i                  downstream ready; a word leaves only when valid_o is also high
//  valid_o/data_o/last_o  head entry, held stable until it is popped
//  count_o                number of buffered words (0..2)
module lrf_axis_skid2 #(
  parameter int unsigned Width = 128
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [Width-1:0] push_data_i,
  input  logic             push_last_i,
  input  logic             pop_i,
  output logic             valid_o,
  output logic [Width-1:0] data_o,
  output logic             last_o,
  output logic [1:0]       count_o
);

  logic [Width-1:0] data0_q, data0_d, data1_q, data1_d;
  logic             last0_q, last0_d, last1_q, last1_d;
  logic [1:0]       count_q, count_d;
  logic             pop;

  assign pop = pop_i && (count_q != 2'd0);

  always_comb begin
    data0_d = data0_q;
    data1_d = data1_q;
    last0_d = last0_q;
    last1_d = last1_q;
    count_d = count_q;
    if (pop) begin
      data0_d = data1_q;
      last0_d = last1_q;
      count_d = count_d - 2'd1;
    end
    // Push lands in the first free slot after any pop this cycle.
    if (push_i) begin
      if (count_d == 2'd0) begin
        data0_d = push_data_i;
        last0_d = push_last_i;
      end else begin
        data1_d = push_data_i;
        last1_d = push_last_i;
      end
      count_d = count_d + 2'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      data0_q <= '0;
      data1_q <= '0;
      last0_q <= 1'b0;
      last1_q <= 1'b0;
      count_q <= 2'd0;
    end else begin
      data0_q <= data0_d;
      data1_q <= data1_d;
      last0_q <= last0_d;
      last1_q <= last1_d;
      count_q <= count_d;
    end
  end

  assign valid_o = (count_q != 2'd0);
  assign data_o  = data0_q;
  assign last_o  = last0_q;
  assign count_o = count_q;

endmodule

// File: rtl/lrf_frame_feeder.sv
// AXI4-Stream transmitter feeding the LRF core from a frame store.
// Streams 2*N_IMAGES frames in interleaved new/old order, then PIPELINE_DELAY zero beats,
// then pulses done.
//  s_axis_aclk, s_axis_aresetn   clock, async active-low reset
//  start                          run request (ignored while busy)
//  busy, done                     run in progress / one-cycle completion pulse
//  mem_rd_en, mem_rd_addr         frame-store read request
//  mem_rd_data                    read data, one cycle after mem_rd_en
//  m_axis_*                       output stream
module lrf_frame_feeder
  import lrf_pkg::*;
#(
  parameter int unsigned PIXEL_WIDTH     = 8,
  parameter int unsigned PIXELS_PER_BEAT = 16,
  parameter int unsigned IMAGE_DIM       = 512,
  parameter int unsigned N_IMAGES        = 5,
  parameter int unsigned N_FUSE_COUNT    = 4,
  parameter int unsigned PIPELINE_DELAY  = 10,
  parameter int unsigned WORD_W          = calc_word_w(PIXEL_WIDTH, PIXELS_PER_BEAT),
  parameter int unsigned ADDR_W          =
      $clog2(N_IMAGES * calc_words(IMAGE_DIM, PIXELS_PER_BEAT))
) (
  input  logic              s_axis_aclk,
  input  logic              s_axis_aresetn,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_rd_addr,
  input  logic [WORD_W-1:0] mem_rd_data,
  output logic [WORD_W-1:0] m_axis_tdata,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready,
  output logic              m_axis_tlast
);

  localparam int unsigned Words   = calc_words(IMAGE_DIM, PIXELS_PER_BEAT);
  localparam int unsigned Offs    = calc_offs(N_FUSE_COUNT);
  localparam int unsigned NFrames = 2 * N_IMAGES;

  lrf_state_t  state_q, state_d;
  logic [31:0] fp_q, fp_d;
  logic [31:0] b_q, b_d;
  logic [31:0] flush_cnt_q, flush_cnt_d;
  logic        inflight_q, inflight_d;
  logic        inflight_last_q, inflight_last_d;

  logic              sk_valid, sk_last, pop;
  logic [WORD_W-1:0] sk_data, push_data;
  logic [1:0]        sk_count;
  logic              push_valid, push_last;
  logic [2:0]        occ;
  logic              rd_en, last_beat, last_read, flush_push, drain_done;
  logic [31:0]       addr_full;

  assign pop = sk_valid && m_axis_tready;

  // Occupancy seen by the next read: credit the word leaving this cycle so that
  // a full-rate stream keeps one word buffered and one in flight.
  assign occ = {1'b0, sk_count} + {2'b00, inflight_q} - {2'b00, pop};

  assign rd_en     = (state_q == StStream) && (occ < 3'd2);
  assign last_beat = (b_q == Words - 1);
  assign last_read = last_beat && (fp_q == NFrames - 1);
  assign addr_full = frame_sel(fp_q, Offs) * Words + b_q;

  // Returning read data always wins the push port; zero beats only fill behind it.
  assign flush_push = (state_q == StFlush) && !inflight_q && (flush_cnt_q < PIPELINE_DELAY) &&
                      ((sk_count != 2'd2) || pop);
  assign push_valid = inflight_q || flush_push;
  assign push_data  = inflight_q ? mem_rd_data : '0;
  assign push_last  = inflight_q && inflight_last_q;

  // True when the buffer empties by the end of this cycle with nothing left in flight.
  assign drain_done = !inflight_q && ((sk_count == 2'd0) || ((sk_count == 2'd1) && pop));

  always_comb begin
    state_d         = state_q;
    fp_d            = fp_q;
    b_d             = b_q;
    flush_cnt_d     = flush_cnt_q;
    inflight_d      = rd_en;
    inflight_last_d = rd_en && last_beat;
    case (state_q)
      StIdle: begin
        if (start) begin
          state_d     = StStream;
          fp_d        = 32'd0;
          b_d         = 32'd0;
          flush_cnt_d = 32'd0;
        end
      end
      StStream: begin
        if (rd_en) begin
          if (last_beat) begin
            b_d  = 32'd0;
            fp_d = fp_q + 32'd1;
          end else begin
            b_d = b_q + 32'd1;
          end
          if (last_read) begin
            state_d = StFlush;
          end
        end
      end
      StFlush: begin
        if (flush_push) begin
          flush_cnt_d = flush_cnt_q + 32'd1;
        end
        if ((flush_cnt_q == PIPELINE_DELAY) && drain_done) begin
          state_d = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
    if (!s_axis_aresetn) begin
      state_q         <= StIdle;
      fp_q            <= 32'd0;
      b_q             <= 32'd0;
      flush_cnt_q     <= 32'd0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      fp_q            <= fp_d;
      b_q             <= b_d;
      flush_cnt_q     <= flush_cnt_d;
      inflight_q      <= inflight_d;
      inflight_last_q <= inflight_last_d;
    end
  end

  lrf_axis_skid2 #(
    .Width (WORD_W)
  ) u_skid (
    .clk_i       (s_axis_aclk),
    .rst_ni      (s_axis_aresetn),
    .push_i      (push_valid),
    .push_data_i (push_data),
    .push_last_i (push_last),
    .pop_i       (m_axis_tready),
    .valid_o     (sk_valid),
    .data_o      (sk_data),
    .last_o      (sk_last),
    .count_o     (sk_count)
  );

  assign busy          = (state_q != StIdle);
  assign done          = (state_q == StDone);
  assign mem_rd_en     = rd_en;
  assign mem_rd_addr   = rd_en ? addr_full[ADDR_W-1:0] : '0;
  assign m_axis_tvalid = sk_valid;
  assign m_axis_tdata  = sk_data;
  assign m_axis_tlast  = sk_last;

endmodule

// File: tb/tb_lrf_frame_feeder.sv
// Bench for lrf_frame_feeder with WORDS=4, N_IMAGES=3, OFFS=1.
// Two instances share start/tready/reset: dut_a (PIPELINE_DELAY=2) and dut_b (PIPELINE_DELAY=0);
// sel picks which one the monitor observes.
module tb_lrf_frame_feeder;

  localparam int WW    = 128;
  localparam int AW    = 4;
  localparam int WORDS = 4;
  localparam int NI    = 3;
  localparam int OFFS  = 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic tready = 1'b1;

  logic          a_busy, a_done, a_rd, a_tvalid, a_tlast;
  logic [AW-1:0] a_addr;
  logic [WW-1:0] a_rdata, a_tdata;
  logic          b_busy, b_done, b_rd, b_tvalid, b_tlast;
  logic [AW-1:0] b_addr;
  logic [WW-1:0] b_rdata, b_tdata;

  always #5 clk = ~clk;

  lrf_frame_feeder #(
    .PIXEL_WIDTH(8), .PIXELS_PER_BEAT(16), .IMAGE_DIM(8), .N_IMAGES(3),
    .N_FUSE_COUNT(0), .PIPELINE_DELAY(2)
  ) dut_a (
    .s_axis_aclk(clk), .s_axis_aresetn(rst_n), .start(start), .busy(a_busy), .done(a_done),
    .mem_rd_en(a_rd), .mem_rd_addr(a_addr), .mem_rd_data(a_rdata), .m_axis_tdata(a_tdata),
    .m_axis_tvalid(a_tvalid), .m_axis_tready(tready), .m_axis_tlast(a_tlast)
  );

  lrf_frame_feeder #(
    .PIXEL_WIDTH(8), .PIXELS_PER_BEAT(16), .IMAGE_DIM(8), .N_IMAGES(3),
    .N_FUSE_COUNT(0), .PIPELINE_DELAY(0)
  ) dut_b (
    .s_axis_aclk(clk), .s_axis_aresetn(rst_n), .start(start), .busy(b_busy), .done(b_done),
    .mem_rd_en(b_rd), .mem_rd_addr(b_addr), .mem_rd_data(b_rdata), .m_axis_tdata(b_tdata),
    .m_axis_tvalid(b_tvalid), .m_axis_tready(tready), .m_axis_tlast(b_tlast)
  );

  // Frame store: mem[a] = a, one-cycle read latency.
  always @(posedge clk) begin
    if (a_rd) a_rdata <= WW'(a_addr);
    if (b_rd) b_rdata <= WW'(b_addr);
  end

  int checks = 0;
  int failures = 0;

  int sel = 0;
  int mode = 0;
  bit clr_req = 1'b0;
  int stall_done = 0;

  // Monitor state
  int            cyc = 0;
  logic [WW-1:0] cap_d[$];
  bit            cap_l[$];
  int            hs_last, done_cyc, done_cnt, start_cyc, issued, consumed, max_out, stall_bad;
  bit            start_seen, prev_stall, prev_l;
  logic [WW-1:0] prev_d;

  // Expected stream from the model
  logic [WW-1:0] exp_d[$];
  bit            exp_l[$];

  typedef struct {
    int word;
    bit last;
  } vec_t;
  vec_t tbl[26];

  task automatic check(input string name, input logic [WW-1:0] act, input logic [WW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Backpressure: 0 = always ready, 1 = random 50%, 2 = five-cycle stall from beat 6.
  always @(posedge clk) begin
    #1;
    if (clr_req) stall_done = 0;
    case (mode)
      0: tready = 1'b1;
      1: tready = 1'($urandom_range(0, 1));
      default: begin
        if (cap_d.size() >= 6 && stall_done < 5) begin
          tready = 1'b0;
          stall_done++;
        end else begin
          tready = 1'b1;
        end
      end
    endcase
  end

  always @(negedge clk) begin
    logic          v, l, rd, dn;
    logic [WW-1:0] d;
    cyc++;
    v  = (sel != 0) ? b_tvalid : a_tvalid;
    l  = (sel != 0) ? b_tlast : a_tlast;
    d  = (sel != 0) ? b_tdata : a_tdata;
    rd = (sel != 0) ? b_rd : a_rd;
    dn = (sel != 0) ? b_done : a_done;
    if (clr_req) begin
      cap_d.delete();
      cap_l.delete();
      hs_last = 0; done_cyc = 0; done_cnt = 0; start_cyc = 0; issued = 0; consumed = 0;
      max_out = 0; stall_bad = 0; start_seen = 0; prev_stall = 0;
    end else if (rst_n) begin
      if (start && !start_seen) begin
        start_seen = 1;
        start_cyc = cyc;
      end
      if (prev_stall && (!v || d !== prev_d || l !== prev_l)) stall_bad++;
      prev_stall = v && !tready;
      prev_d = d;
      prev_l = l;
      if (v && tready) begin
        cap_d.push_back(d);
        cap_l.push_back(l);
        hs_last = cyc;
        consumed++;
      end
      if (rd) issued++;
      if (issued - consumed > max_out) max_out = issued - consumed;
      if (dn) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
  end

  function automatic void build_model(input int pd);
    int frame;
    exp_d.delete();
    exp_l.delete();
    for (int fp = 0; fp < 2 * NI; fp++) begin
      if (fp % 2 == 0) frame = fp / 2;
      else frame = (fp > 2 * OFFS) ? fp / 2 - OFFS : 0;
      for (int b = 0; b < WORDS; b++) begin
        exp_d.push_back(WW'(frame * WORDS + b));
        exp_l.push_back(b == WORDS - 1);
      end
    end
    for (int i = 0; i < pd; i++) begin
      exp_d.push_back('0);
      exp_l.push_back(1'b0);
    end
  endfunction

  task automatic wait_idle();
    int n;
    for (n = 0; n < 300; n++) begin
      if (!a_busy && !b_busy) break;
      @(posedge clk);
    end
    check("idle_before_run", WW'(n < 300), WW'(1));
    @(posedge clk);
    #1;
  endtask

  task automatic do_run(input int s, input int tmode, input int again_at, input int rst_at);
    int n;
    bit did;
    wait_idle();
    sel = s;
    mode = tmode;
    clr_req = 1'b1;
    @(posedge clk);
    @(negedge clk);
    #1 clr_req = 1'b0;
    @(posedge clk);
    #1 start = 1'b1;
    did = 1'b0;
    for (n = 0; n < 3000; n++) begin
      @(posedge clk);
      #1;
      if (start) start = 1'b0;
      if (again_at >= 0 && !did && cap_d.size() >= again_at) begin
        start = 1'b1;
        did = 1'b1;
      end
      if (rst_at >= 0 && cap_d.size() >= rst_at) begin
        rst_n = 1'b0;
        repeat (2) begin
          @(negedge clk);
          check("reset_tvalid", WW'(a_tvalid), WW'(0));
          check("reset_busy", WW'(a_busy), WW'(0));
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        return;
      end
      if (done_cnt > 0) break;
    end
    check("run_completes", WW'(done_cnt > 0), WW'(1));
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic check_run(input int pd, input bit timed);
    int bad, first;
    build_model(pd);
    check("beat_count", WW'(cap_d.size()), WW'(exp_d.size()));
    bad = 0;
    first = -1;
    for (int i = 0; i < exp_d.size() && i < cap_d.size(); i++) begin
      if (cap_d[i] !== exp_d[i] || cap_l[i] !== exp_l[i]) begin
        bad++;
        if (first < 0) first = i;
      end
    end
    if (bad != 0) $display("first differing beat %0d", first);
    check("sequence_bad_beats", WW'(bad), WW'(0));
    check("done_pulse_count", WW'(done_cnt), WW'(1));
    check("done_after_last_hs", WW'(done_cyc), WW'(hs_last + 1));
    if (timed) check("done_latency", WW'(done_cyc - start_cyc), WW'(3 + exp_d.size()));
    check("outstanding_le_2", WW'(max_out <= 2), WW'(1));
    check("stable_under_stall", WW'(stall_bad), WW'(0));
  endtask

  initial begin
    int t1w[26];
    logic [WW-1:0] d;
    logic l;
    t1w = '{0, 1, 2, 3, 0, 1, 2, 3, 4, 5, 6, 7, 0, 1, 2, 3, 8, 9, 10, 11, 4, 5, 6, 7, 0, 0};
    for (int i = 0; i < 26; i++) begin
      tbl[i].word = t1w[i];
      tbl[i].last = (i % 4 == 3) && (i < 24);
    end

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_tvalid_a", WW'(a_tvalid), WW'(0));
    check("rst_busy_a", WW'(a_busy), WW'(0));
    check("rst_done_a", WW'(a_done), WW'(0));
    check("rst_rd_en_a", WW'(a_rd), WW'(0));
    check("rst_tdata_a", a_tdata, WW'(0));
    check("rst_tvalid_b", WW'(b_tvalid), WW'(0));
    @(posedge clk);
    #1 rst_n = 1'b1;

    // 1: full rate
    do_run(0, 0, -1, -1);
    for (int i = 0; i < 26; i++) begin
      d = (i < cap_d.size()) ? cap_d[i] : 'x;
      l = (i < cap_l.size()) ? cap_l[i] : 1'bx;
      check($sformatf("t1_beat%0d_data", i), d, WW'(tbl[i].word));
      check($sformatf("t1_beat%0d_last", i), WW'(l), WW'(tbl[i].last));
    end
    check_run(2, 1);

    // 2: five-cycle stall mid-frame
    do_run(0, 2, -1, -1);
    check_run(2, 0);

    // 3: random backpressure
    do_run(0, 1, -1, -1);
    check_run(2, 0);

    // 4: start pulsed while busy
    do_run(0, 0, 10, -1);
    check_run(2, 1);

    // 5: reset mid-run, then a clean restart
    do_run(0, 0, -1, 13);
    check("post_reset_tvalid", WW'(a_tvalid), WW'(0));
    do_run(0, 0, -1, -1);
    check_run(2, 1);

    // 6: PIPELINE_DELAY = 0
    do_run(1, 0, -1, -1);
    check_run(0, 1);
    do_run(1, 1, -1, -1);
    check_run(0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
